// File: rtl/health_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : health_pkg
//  Description : Shared result codes and FSM state encoding for the
//                nervous-shock channel scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package health_pkg;

   // Detector abnormality codes
   localparam logic [1:0] CODE_NORMAL = 2'b00;
   localparam logic [1:0] CODE_MILD   = 2'b01;
   localparam logic [1:0] CODE_MOD    = 2'b10;
   localparam logic [1:0] CODE_SHOCK  = 2'b11;

   // Scheduler FSM states
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_CLEAR  = 3'd2,
      ST_SHIFT  = 3'd3,
      ST_SETTLE = 3'd4,
      ST_REPORT = 3'd5
   } state_t;

   // Any code other than normal raises the channel alarm
   function automatic logic is_abnormal(input logic [1:0] code);
      return (code != CODE_NORMAL);
   endfunction

   // A shock code on a first scan triggers a confirming re-scan
   function automatic logic is_shock(input logic [1:0] code);
      return (code == CODE_SHOCK);
   endfunction

endpackage : health_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational rotate-priority arbiter. Grants the first
//                requesting index at or after ptr, wrapping around.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
   parameter int NUM_CH = 4
) (
   input  logic [NUM_CH-1:0]         req,
   input  logic [$clog2(NUM_CH)-1:0] ptr,
   output logic [$clog2(NUM_CH)-1:0] grant,
   output logic                      any_req
);

   localparam int c_cw = $clog2(NUM_CH);

   logic [NUM_CH-1:0] w_mask;
   logic [NUM_CH-1:0] w_hi;
   logic [NUM_CH-1:0] w_pool;
   logic [NUM_CH-1:0] w_onehot;

   // Prefer requests at or above ptr; fall back to the wrapped set, then
   // isolate the lowest set bit of the chosen pool and encode it.
   always_comb begin
      w_mask = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         w_mask[i] = (i >= int'(ptr));
      end
      w_hi     = req & w_mask;
      w_pool   = (|w_hi) ? w_hi : req;
      w_onehot = w_pool & (~w_pool + NUM_CH'(1));
      grant    = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (w_onehot[i]) begin
            grant = c_cw'(i);
         end
      end
   end

   assign any_req = |req;

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/nervous_channel_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : nervous_channel_scheduler
//  Description : Time-shares one serial nervous-shock detector among NUM_CH
//                sensor channels. Grants round-robin, serializes the window
//                MSB-first, samples the 2-bit result, re-scans once on a
//                shock code, and keeps sticky per-channel alarms.
//  Revision    : 1.0 - initial release
// ============================================================================
module nervous_channel_scheduler
   import health_pkg::*;
#(
   parameter int NUM_CH   = 4,
   parameter int WIN_BITS = 8,
   parameter int SETTLE   = 2
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [NUM_CH-1:0]            ch_valid,
   input  logic [NUM_CH*WIN_BITS-1:0]   ch_data,
   output logic [NUM_CH-1:0]            ch_ready,
   output logic                         det_clear,
   output logic                         det_inputdata,
   input  logic [1:0]                   det_result,
   output logic                         res_valid,
   output logic [$clog2(NUM_CH)-1:0]    res_channel,
   output logic [1:0]                   res_code,
   output logic [NUM_CH-1:0]            alarm,
   input  logic [NUM_CH-1:0]            alarm_ack
);

   localparam int c_cw = $clog2(NUM_CH);
   localparam int c_bw = $clog2(WIN_BITS + 1);
   localparam int c_sw = $clog2(SETTLE + 1);

   state_t                r_state;
   logic [c_cw-1:0]       r_ptr;
   logic [c_cw-1:0]       r_grant;
   logic                  r_retry;
   logic [WIN_BITS-1:0]   r_window;
   logic [WIN_BITS-1:0]   r_shift;
   logic [c_bw-1:0]       r_bitcnt;
   logic [c_sw-1:0]       r_setcnt;

   logic [c_cw-1:0]       w_arb_grant;
   logic                  w_any_req;
   logic [WIN_BITS-1:0]   w_sel_data;
   logic [NUM_CH-1:0]     w_alarm_set;

   rr_arbiter #(
      .NUM_CH (NUM_CH)
   ) u_arb (
      .req     (ch_valid),
      .ptr     (r_ptr),
      .grant   (w_arb_grant),
      .any_req (w_any_req)
   );

   // Window of the currently granted channel
   always_comb begin
      w_sel_data = ch_data[int'(r_grant)*WIN_BITS +: WIN_BITS];
   end

   // Alarm set request: the reported code is held in res_code during REPORT
   always_comb begin
      w_alarm_set = '0;
      if (r_state == ST_REPORT && is_abnormal(res_code)) begin
         w_alarm_set = NUM_CH'(1) << r_grant;
      end
   end

   // Scheduler FSM; every strobe is registered on entry to the state it marks
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_ptr         <= '0;
         r_grant       <= '0;
         r_retry       <= 1'b0;
         r_window      <= '0;
         r_shift       <= '0;
         r_bitcnt      <= '0;
         r_setcnt      <= '0;
         ch_ready      <= '0;
         det_clear     <= 1'b0;
         det_inputdata <= 1'b0;
         res_valid     <= 1'b0;
         res_channel   <= '0;
         res_code      <= CODE_NORMAL;
      end else begin
         ch_ready      <= '0;
         det_clear     <= 1'b0;
         det_inputdata <= 1'b0;
         res_valid     <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_any_req) begin
                  r_grant  <= w_arb_grant;
                  ch_ready <= NUM_CH'(1) << w_arb_grant;
                  r_state  <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               r_window  <= w_sel_data;
               det_clear <= 1'b1;
               r_state   <= ST_CLEAR;
            end
            ST_CLEAR: begin
               // MSB goes out now; the shifter supplies the rest
               det_inputdata <= r_window[WIN_BITS-1];
               r_shift       <= r_window << 1;
               r_bitcnt      <= c_bw'(WIN_BITS - 1);
               r_state       <= ST_SHIFT;
            end
            ST_SHIFT: begin
               if (r_bitcnt != '0) begin
                  det_inputdata <= r_shift[WIN_BITS-1];
                  r_shift       <= r_shift << 1;
                  r_bitcnt      <= r_bitcnt - c_bw'(1);
               end else begin
                  r_setcnt <= c_sw'(SETTLE - 1);
                  r_state  <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (r_setcnt != '0) begin
                  r_setcnt <= r_setcnt - c_sw'(1);
               end else begin
                  res_valid   <= 1'b1;
                  res_code    <= det_result;
                  res_channel <= r_grant;
                  r_state     <= ST_REPORT;
               end
            end
            ST_REPORT: begin
               if (is_shock(res_code) && !r_retry) begin
                  // Confirm a shock by re-scanning the latched window
                  r_retry   <= 1'b1;
                  det_clear <= 1'b1;
                  r_state   <= ST_CLEAR;
               end else begin
                  r_retry <= 1'b0;
                  r_ptr   <= (r_grant == c_cw'(NUM_CH - 1)) ? '0 : r_grant + c_cw'(1);
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Sticky alarms: a same-cycle set overrides the acknowledge
   always_ff @(posedge clock) begin
      if (reset) begin
         alarm <= '0;
      end else begin
         alarm <= (alarm & ~alarm_ack) | w_alarm_set;
      end
   end

endmodule : nervous_channel_scheduler
`default_nettype wire

// File: tb/tb_nervous_channel_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nervous_channel_scheduler
//  Description : Self-checking bench for nervous_channel_scheduler with a
//                transaction-timeline reference model and directed tests.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nervous_channel_scheduler;

   localparam int NUM_CH = 4;
   localparam int W      = 8;
   localparam int ST     = 2;

   logic              clock = 1'b0;
   logic              reset;
   logic [NUM_CH-1:0] ch_valid;
   logic [NUM_CH*W-1:0] ch_data;
   logic [NUM_CH-1:0] ch_ready;
   logic              det_clear;
   logic              det_inputdata;
   logic [1:0]        det_result;
   logic              res_valid;
   logic [1:0]        res_channel;
   logic [1:0]        res_code;
   logic [NUM_CH-1:0] alarm;
   logic [NUM_CH-1:0] alarm_ack;

   nervous_channel_scheduler #(
      .NUM_CH   (NUM_CH),
      .WIN_BITS (W),
      .SETTLE   (ST)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .ch_valid      (ch_valid),
      .ch_data       (ch_data),
      .ch_ready      (ch_ready),
      .det_clear     (det_clear),
      .det_inputdata (det_inputdata),
      .det_result    (det_result),
      .res_valid     (res_valid),
      .res_channel   (res_channel),
      .res_code      (res_code),
      .alarm         (alarm),
      .alarm_ack     (alarm_ack)
   );

   always #5 clock = ~clock;

   int tests = 0;
   int fails = 0;
   bit check_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- reference model: expected per-cycle timeline ----------
   typedef struct {
      logic [NUM_CH-1:0] rdy;
      logic              clr;
      int                bitpos;   // window bit on det_inputdata, -1 = none
      logic              rv;
   } slot_t;

   slot_t       q[$];
   int          m_ptr = 0;
   int          m_ch = 0;
   bit          m_retry = 1'b0;
   logic [NUM_CH-1:0] m_alarm = '0;
   logic [W-1:0] m_window = '0;
   logic [1:0]  m_prev_det = 2'b00;
   int          m_res_ch = 0;
   logic [1:0]  m_res_code = 2'b00;

   // One scan of the detector: optional accept cycle, clear, bits, settle, report
   task automatic push_scan(input bit with_load, input int ch);
      slot_t s;
      if (with_load) begin
         s = '{rdy: NUM_CH'(1) << ch, clr: 1'b0, bitpos: -1, rv: 1'b0};
         q.push_back(s);
      end
      s = '{rdy: '0, clr: 1'b1, bitpos: -1, rv: 1'b0};
      q.push_back(s);
      for (int b = W - 1; b >= 0; b--) begin
         s = '{rdy: '0, clr: 1'b0, bitpos: b, rv: 1'b0};
         q.push_back(s);
      end
      for (int k = 0; k < ST; k++) begin
         s = '{rdy: '0, clr: 1'b0, bitpos: -1, rv: 1'b0};
         q.push_back(s);
      end
      s = '{rdy: '0, clr: 1'b0, bitpos: -1, rv: 1'b1};
      q.push_back(s);
   endtask

   // ---------------- monitor logs for directed checks ----------------------
   int rdy_ch_q[$], rdy_cyc_q[$], res_ch_q[$], res_code_q[$], res_cyc_q[$];
   logic [W-1:0] win_q[$];
   int n_clr = 0, n_rdy = 0, n_res = 0, cyc = 0, collect = 0;
   logic [W-1:0] wbits = '0;

   task automatic clear_logs();
      rdy_ch_q.delete(); rdy_cyc_q.delete();
      res_ch_q.delete(); res_code_q.delete(); res_cyc_q.delete();
      win_q.delete();
      n_clr = 0; n_rdy = 0; n_res = 0;
   endtask

   // Compare DUT against the model, log events, then advance the model
   always @(negedge clock) begin
      slot_t e;
      bit    was_idle;
      if (check_en) begin
         cyc++;
         was_idle = (q.size() == 0);
         if (was_idle) e = '{rdy: '0, clr: 1'b0, bitpos: -1, rv: 1'b0};
         else          e = q[0];
         if (e.rv) begin
            m_res_ch   = m_ch;
            m_res_code = m_prev_det;
         end
         check("ch_ready", ch_ready, e.rdy);
         check("det_clear", det_clear, e.clr);
         check("det_inputdata", det_inputdata, (e.bitpos >= 0) ? m_window[e.bitpos] : 1'b0);
         check("res_valid", res_valid, e.rv);
         check("res_channel", res_channel, m_res_ch);
         check("res_code", res_code, m_res_code);
         check("alarm", alarm, m_alarm);

         if (ch_ready != '0) begin
            n_rdy++;
            for (int i = 0; i < NUM_CH; i++) if (ch_ready[i]) rdy_ch_q.push_back(i);
            rdy_cyc_q.push_back(cyc);
         end
         if (det_clear) begin
            n_clr++;
            collect = W;
         end else if (collect > 0) begin
            wbits = {wbits[W-2:0], det_inputdata};
            collect--;
            if (collect == 0) win_q.push_back(wbits);
         end
         if (res_valid) begin
            n_res++;
            res_ch_q.push_back(int'(res_channel));
            res_code_q.push_back(int'(res_code));
            res_cyc_q.push_back(cyc);
         end

         if (reset) begin
            q.delete();
            m_ptr = 0; m_retry = 1'b0; m_alarm = '0;
            m_res_ch = 0; m_res_code = 2'b00;
            collect = 0;
         end else begin
            if (!was_idle) void'(q.pop_front());
            if (e.rdy != '0) m_window = ch_data[m_ch*W +: W];
            m_alarm = m_alarm & ~alarm_ack;
            if (e.rv) begin
               if (m_res_code != 2'b00) m_alarm[m_ch] = 1'b1;
               if (m_res_code == 2'b11 && !m_retry) begin
                  m_retry = 1'b1;
                  push_scan(1'b0, m_ch);
               end else begin
                  m_retry = 1'b0;
                  m_ptr   = (m_ch + 1) % NUM_CH;
               end
            end
            if (was_idle && ch_valid != '0) begin
               for (int k = 0; k < NUM_CH; k++) begin
                  if (ch_valid[(m_ptr + k) % NUM_CH]) begin
                     m_ch = (m_ptr + k) % NUM_CH;
                     break;
                  end
               end
               push_scan(1'b1, m_ch);
            end
         end
         m_prev_det = det_result;
      end
   end

   // ---------------- stimulus helpers ---------------------------------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_rdy(input int n, input int budget);
      int k = 0;
      while (rdy_ch_q.size() < n && k < budget) begin tick(); k++; end
      check("rdy_count_reached", rdy_ch_q.size(), n);
   endtask

   task automatic wait_res(input int n, input int budget);
      int k = 0;
      while (res_ch_q.size() < n && k < budget) begin tick(); k++; end
      check("res_count_reached", res_ch_q.size(), n);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- directed tests ------------------------------------------
   initial begin
      int k;
      int exp_rr [5] = '{0, 1, 2, 3, 0};
      reset = 1'b1; ch_valid = '0; ch_data = '0; det_result = 2'b00; alarm_ack = '0;
      @(posedge clock); #1;
      check_en = 1'b1;
      tick();
      reset = 1'b0;

      // Single channel, window A5, normal result
      clear_logs();
      ch_data[7:0] = 8'hA5; ch_valid = 4'b0001;
      wait_rdy(1, 20);
      ch_valid = '0;
      wait_res(1, 30);
      tick(); tick();
      check("t1_ready_pulses", n_rdy, 1);
      check("t1_ready_channel", rdy_ch_q[0], 0);
      check("t1_window_bits", win_q[0], 8'hA5);
      check("t1_grant_to_res_latency", res_cyc_q[0] - (rdy_cyc_q[0] - 1), 13);
      check("t1_code", res_code_q[0], 0);
      check("t1_alarm", alarm, 4'b0000);

      // Round-robin fairness from pointer 0
      reset = 1'b1; tick(); reset = 1'b0;
      clear_logs();
      ch_data = {8'h3C, 8'h0F, 8'hF0, 8'h81};
      ch_valid = 4'b1111;
      wait_rdy(5, 100);
      ch_valid = '0;
      wait_res(5, 40);
      for (int i = 0; i < 5; i++) check("t2_rr_order", res_ch_q[i], exp_rr[i]);
      check("t2_window_ch1", win_q[1], 8'hF0);

      // Escalation on channel 1
      reset = 1'b1; tick(); reset = 1'b0;
      clear_logs();
      ch_data[15:8] = 8'h5A; ch_valid = 4'b0010; det_result = 2'b11;
      wait_rdy(1, 20);
      ch_valid = '0;
      wait_res(2, 60);
      repeat (20) tick();
      check("t3_ready_pulses", n_rdy, 1);
      check("t3_result_count", n_res, 2);
      check("t3_res0_ch", res_ch_q[0], 1);
      check("t3_res1_ch", res_ch_q[1], 1);
      check("t3_res1_code", res_code_q[1], 3);
      check("t3_rescan_gap", res_cyc_q[1] - res_cyc_q[0], 12);
      check("t3_rescan_window", win_q[1], 8'h5A);
      check("t3_alarm", alarm, 4'b0010);
      clear_logs();
      det_result = 2'b00; ch_valid = 4'b1111;
      wait_rdy(1, 20);
      ch_valid = '0;
      check("t3_ptr_after_retry", rdy_ch_q[0], 2);
      wait_res(1, 30);

      // Alarm acknowledge, then set-versus-ack race on channel 2
      alarm_ack = 4'b0010; tick(); alarm_ack = '0; tick();
      check("t4_ack_clears", alarm, 4'b0000);
      clear_logs();
      ch_valid = 4'b0100; det_result = 2'b10;
      wait_rdy(1, 20);
      ch_valid = '0;
      k = 0;
      while (res_valid !== 1'b1 && k < 30) begin tick(); k++; end
      check("t4_report_seen", res_valid, 1'b1);
      alarm_ack = 4'b0100; tick(); alarm_ack = '0;
      check("t4_set_wins", alarm, 4'b0100);
      tick();
      alarm_ack = 4'b0100; tick(); alarm_ack = '0;
      check("t4_later_ack", alarm, 4'b0000);

      // Reset in the 4th SHIFT cycle of channel 3 (pointer is 3 here)
      clear_logs();
      det_result = 2'b00; ch_data[31:24] = 8'hC3; ch_valid = 4'b1000;
      wait_rdy(1, 20);
      ch_valid = '0;
      repeat (4) tick();
      reset = 1'b1; tick(); reset = 1'b0;
      check("t5_ch_ready", ch_ready, 4'b0000);
      check("t5_det_clear", det_clear, 1'b0);
      check("t5_det_inputdata", det_inputdata, 1'b0);
      check("t5_res_valid", res_valid, 1'b0);
      check("t5_res_channel", res_channel, 2'd0);
      check("t5_res_code", res_code, 2'b00);
      check("t5_no_aborted_result", n_res, 0);
      clear_logs();
      ch_data[7:0] = 8'h66; ch_valid = 4'b1001;
      wait_rdy(1, 20);
      ch_valid = '0;
      check("t5_ptr_reset", rdy_ch_q[0], 0);
      wait_res(1, 30);
      check("t5_first_res_ch", res_ch_q[0], 0);
      check("t5_window", win_q[0], 8'h66);

      // Idle: nothing pending for 20 cycles
      tick();
      clear_logs();
      ch_valid = '0;
      repeat (20) tick();
      check("t6_idle_clear", n_clr, 0);
      check("t6_idle_ready", n_rdy, 0);
      check("t6_idle_res", n_res, 0);

      tick(); tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_nervous_channel_scheduler
`default_nettype wire
